// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI types and word/lead-in defaults for spi_slave_rx and fsm_spi.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT} state_type;

   localparam int SPI_DATA_W     = 8;
   localparam int SPI_LEAD_EDGES = 1;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Serial link plus parallel valid/ready word port of spi_slave_rx.
interface spi_slave_rx_if
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
);
   logic              cs;
   logic              sclk;
   logic              mosi;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              overrun;
   logic              frame_err;
   logic              busy;

   modport master (
      output cs, sclk, mosi, rx_ready,
      input  rx_data, rx_valid, overrun, frame_err, busy
   );

   modport slave (
      input  cs, sclk, mosi, rx_ready,
      output rx_data, rx_valid, overrun, frame_err, busy
   );
endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// Input conditioning: optional 2-flop synchronizer (SPI_RX_SYNC_EN) on a bus,
// with a delay flop and rise/fall detect on bit 0.
module spi_sync_edge #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         rise,
   output logic         fall
);
   logic q0_d;

`ifdef SPI_RX_SYNC_EN
   logic [W-1:0] s1;
   logic [W-1:0] s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;
`else
   assign q = d;
`endif

   always_ff @(posedge clk) begin
      if (rst) q0_d <= RST_VAL[0];
      else     q0_d <= q[0];
   end

   assign rise = q[0] & ~q0_d;
   assign fall = ~q[0] & q0_d;
endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: oversampled cs/sclk/mosi, lead-in discard, MSB-first shift,
// one-word holding register. SPI_RX_SYNC_EN adds a 2-flop input synchronizer.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int LEAD_EDGES  = SPI_LEAD_EDGES,
   parameter bit SAMPLE_FALL = 1'b1
) (
   input logic          clk,
   input logic          rst,
   spi_slave_rx_if.slave bus
);
   localparam int                CNT_W     = $clog2(DATA_W + 1);
   localparam int                LEAD_W    = $clog2(LEAD_EDGES + 2);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEAD_EDGES > 0 ? LEAD_EDGES - 1 : 0);

   state_type          state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [LEAD_W-1:0]  lead_cnt;
   logic [DATA_W-2:0]  shift;
   logic [DATA_W-1:0]  word;
   logic               cs_s, mosi_s, sclk_s;
   logic               sclk_rise, sclk_fall, smp;

   // One instance keeps cs/mosi/sclk at identical synchronizer depth.
   spi_sync_edge #(
      .W       (3),
      .RST_VAL (3'b100)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    ({bus.cs, bus.mosi, bus.sclk}),
      .q    ({cs_s, mosi_s, sclk_s}),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   assign smp  = SAMPLE_FALL ? sclk_fall : sclk_rise;
   assign word = {shift, mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         lead_cnt      <= '0;
         shift         <= '0;
         bus.rx_data   <= '0;
         bus.rx_valid  <= 1'b0;
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.overrun   <= 1'b0;
         bus.frame_err <= 1'b0;
         if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!cs_s) begin
                  lead_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= (LEAD_EDGES > 0) ? LEAD : SHIFT;
                  bus.busy <= 1'b1;
               end
            end
            LEAD: begin
               if (cs_s) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else if (smp) begin
                  if (lead_cnt == LEAD_LAST) begin
                     lead_cnt <= '0;
                     state    <= SHIFT;
                  end else begin
                     lead_cnt <= lead_cnt + 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (cs_s) begin
                  if (bit_cnt != '0) bus.frame_err <= 1'b1;
                  bit_cnt  <= '0;
                  shift    <= '0;
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else if (smp) begin
                  shift <= word[DATA_W-2:0];
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     // A same-edge accept frees the holding register for this word.
                     if (!bus.rx_valid || bus.rx_ready) begin
                        bus.rx_data  <= word;
                        bus.rx_valid <= 1'b1;
                     end else begin
                        bus.overrun <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule
